fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Holds the architectural PC and sequences instruction fetch for the RV32I core. Each fetched instruction is presented to decode/execute with a valid/ready handshake. On acceptance, the unit loads the next-PC value computed downstream (`dnpc`) and starts the next fetch. It consumes `dnpc` and drives the `pc` that the next-PC logic reads. It also retires a counter and traps on misaligned targets.

## Interface
Parameters:
- `RESET_PC`, default 32'h00000000: PC value after reset.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dnpc`  in  32  next PC for the instruction currently presented on `inst`. Combinational from downstream; sampled only at issue handshake.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  32  fetch address, equal to `pc`.
- `imem_rsp_valid`  in  1  response data valid.
- `imem_rsp_data`  in  32  fetched instruction word.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode/execute accepts the instruction.
- `inst`  out  32  instruction word.
- `pc`  out  32  PC of the instruction being fetched or presented.
- `instret`  out  32  count of accepted instructions.
- `misalign_err`  out  1  sticky flag: a `dnpc` with bits [1:0] != 0 was taken.

## Operation
- **State machine:** IDLE, FETCH, WAIT, ISSUE, TRAP. Reset enters IDLE.
- **IDLE:** all handshake outputs low. Go to FETCH unconditionally on the next edge.
- **FETCH:**
  - `imem_req_valid`=1, `imem_addr`=`pc`.
  - On `imem_req_valid && imem_req_ready`, go to WAIT.
  - `imem_rsp_valid` is ignored in this state.
- **WAIT:**
  - `imem_req_valid`=0.
  - On `imem_rsp_valid`, latch `imem_rsp_data` into `inst` and go to ISSUE.
  - There is no timeout; WAIT is held indefinitely.
- **ISSUE:**
  - `inst_valid`=1; `inst` and `pc` are stable while `inst_ready`=0.
  - On `inst_valid && inst_ready`: `pc`<=`dnpc` and `instret`<=`instret`+1, with 32-bit wrap (FFFFFFFF->0).
  - If `dnpc[1:0]`==0, go to FETCH. Otherwise set `misalign_err`=1, still load `pc`<=`dnpc`, and go to TRAP.
- **TRAP:** absorbing until reset. All handshake outputs low; `pc`, `instret` and `inst` frozen.
- **`misalign_err`:** cleared only by reset.
- **Arithmetic:** unsigned 32-bit; no overflow detection on `pc` or `instret`.
- **Request stability:** `imem_req_valid` is never deasserted once raised until accepted, and `imem_addr` is never changed while the request is pending.

## Timing
- **Reset values (asynchronous on `rst_n`=0):**
  - state=IDLE, `pc`=`RESET_PC`, `inst`=0, `instret`=0, `misalign_err`=0.
  - `imem_req_valid`=0, `inst_valid`=0.
- **Start-up:** the first request appears in the 2nd cycle after `rst_n` rises (IDLE→FETCH).
- **Minimum loop** with zero-wait memory (ready=1; response the cycle after acceptance; `inst_ready`=1): FETCH 1 + WAIT 1 + ISSUE 1 = 3 cycles per instruction.
- **Latency:** `inst_valid` rises one cycle after the `imem_rsp_valid` edge that was sampled.
- **`pc` update:** `pc` changes on the issue-handshake edge; `imem_addr` shows the new value in the same cycle the FETCH state is entered.
- **`dnpc`:** must be valid in any cycle where `inst_valid && inst_ready`.
- **Reset mid-operation:** any state, including WAIT with an outstanding request, returns to IDLE immediately. A late memory response after reset arrives in IDLE/FETCH and is discarded.

## Test plan
- **Reset and start-up:** `RESET_PC`=0x0; release `rst_n`, memory always ready, 1-cycle response → first `imem_addr`=0x0 at cycle 2; `inst_valid` at cycle 4; all reset values checked while `rst_n`=0.
- **Sequential stream:** `dnpc`=`pc`+4 for 5 instructions → addresses 0x0, 0x4, 0x8, 0xC, 0x10; `instret`=5; 3-cycle cadence.
- **Backpressure:**
  - `imem_req_ready` low for 3 cycles → `imem_req_valid` and `imem_addr` held stable.
  - `inst_ready` low for 4 cycles → `inst` and `pc` stable, `instret` unchanged.
- **Jump/branch redirect:** `dnpc`=0x100 at handshake from `pc`=0x8 → next `imem_addr`=0x100.
- **Misaligned target:** `dnpc`=0x102 → `misalign_err`=1, `pc`=0x102, no further `imem_req_valid`, `instret` incremented once; persists until `rst_n` low.
- **Reset in WAIT and counter wrap:**
  - Assert `rst_n`=0 in WAIT, then deliver `imem_rsp_valid` → response ignored; restart fetch at `RESET_PC`.
  - Force `instret`=0xFFFFFFFF, complete one issue → `instret`=0.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC holder and instruction fetch sequencer for the RV32I core
//
// Purpose:
//   Owns the architectural PC, issues one instruction-memory request per
//   instruction, latches the returned word and presents it to decode/execute.
//   When decode accepts the instruction, the PC loads the next-PC (dnpc)
//   computed downstream and the retired-instruction counter increments. A
//   misaligned dnpc is still loaded, but the unit raises a sticky error and
//   parks in TRAP until reset.
//
// Ports:
//   clk, rst_n         core clock, asynchronous active-low reset
//   dnpc               next PC for the presented instruction (used at issue handshake)
//   imem_req_valid/_ready, imem_addr     fetch request channel (addr == pc)
//   imem_rsp_valid, imem_rsp_data        fetch response channel
//   inst_valid/_ready, inst              instruction channel to decode/execute
//   pc                 PC of the instruction being fetched or presented
//   instret            count of accepted instructions (wraps at 32 bits)
//   misalign_err       sticky: a dnpc with bits [1:0] != 0 was taken

module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dnpc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        misalign_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_TRAP  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] instret_q, instret_d;
  logic        misalign_q, misalign_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= 32'h0;
      instret_q  <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      instret_q  <= instret_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    instret_d      = instret_q;
    misalign_d     = misalign_q;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      // Request is a pure function of state, so it stays up and the address
      // (pc_q) stays fixed until the memory accepts it.
      S_FETCH: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          pc_d      = dnpc;
          instret_d = instret_q + 32'd1;
          if (dnpc[1:0] != 2'b00) begin
            // The bad target is still committed to pc so software can see it.
            misalign_d = 1'b1;
            state_d    = S_TRAP;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign inst         = inst_q;
  assign instret      = instret_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit

module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dnpc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        misalign_err;

  int tests = 0;
  int fails = 0;

  // Reference model: architectural view only (next fetch address, retired count, error flag).
  logic [31:0] m_pc;
  logic [31:0] m_instret;
  logic        m_mis;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dnpc           (dnpc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc),
    .instret        (instret),
    .misalign_err   (misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = RESET_PC;
    m_instret = 32'h0;
    m_mis     = 1'b0;
  endtask

  // One full instruction: fetch request (optionally stalled), response after
  // rsp_delay idle cycles, issue (optionally stalled), handshake with next_pc.
  // Inputs are driven and outputs sampled on the falling edge.
  task automatic run_instr(input logic [31:0] next_pc, input int req_stall,
                           input int rsp_delay, input int issue_stall,
                           input bit want_immediate, input bit wrap);
    int          n;
    logic [31:0] word;
    word = $urandom;
    n = 0;
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("req_seen", imem_req_valid, 1'b1);
    if (want_immediate) chk("cadence_fetch_wait", n, 32'd0);
    chk("req_addr", imem_addr, m_pc);

    for (int i = 0; i < req_stall; i++) begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;   // must be ignored while fetching
      @(negedge clk);
      chk1("req_hold_valid", imem_req_valid, 1'b1);
      chk("req_hold_addr", imem_addr, m_pc);
      chk1("req_hold_no_issue", inst_valid, 1'b0);
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk1("wait_req_low", imem_req_valid, 1'b0);

    for (int i = 0; i < rsp_delay; i++) begin
      @(negedge clk);
      chk1("wait_no_issue", inst_valid, 1'b0);
      chk1("wait_req_low2", imem_req_valid, 1'b0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;

    chk1("issue_valid", inst_valid, 1'b1);
    chk("issue_inst", inst, word);
    chk("issue_pc", pc, m_pc);
    chk("issue_instret", instret, m_instret);

    if (wrap) begin
      force dut.instret_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.instret_q;
      m_instret = 32'hFFFF_FFFF;
      chk("wrap_preload", instret, m_instret);
    end

    for (int i = 0; i < issue_stall; i++) begin
      dnpc = $urandom;         // not a handshake cycle, must not be taken
      @(negedge clk);
      chk1("stall_valid", inst_valid, 1'b1);
      chk("stall_inst", inst, word);
      chk("stall_pc", pc, m_pc);
      chk("stall_instret", instret, m_instret);
    end

    inst_ready = 1'b1;
    dnpc       = next_pc;
    @(negedge clk);
    inst_ready = 1'b0;
    dnpc       = $urandom;

    m_instret = m_instret + 32'd1;
    m_pc      = next_pc;
    if (next_pc[1:0] != 2'b00) m_mis = 1'b1;

    chk("post_pc", pc, m_pc);
    chk("post_instret", instret, m_instret);
    chk1("post_misalign", misalign_err, m_mis);
    chk1("post_inst_valid", inst_valid, 1'b0);
    if (!m_mis) begin
      chk1("next_req_valid", imem_req_valid, 1'b1);
      chk("next_req_addr", imem_addr, m_pc);
    end
  endtask

  initial begin
    logic [31:0] nxt;
    rst_n          = 1'b0;
    dnpc           = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b0;
    model_reset();

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk1("rst_mis", misalign_err, 1'b0);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);

    // Start-up: cycle 1 IDLE, cycle 2 first request.
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    chk1("idle_req_low", imem_req_valid, 1'b0);
    @(negedge clk);
    chk1("first_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr", imem_addr, RESET_PC);
    imem_req_ready = 1'b0;

    // Sequential stream, zero-wait: 0x0 .. 0x10.
    for (int k = 0; k < 5; k++) run_instr(m_pc + 32'd4, 0, 0, 0, 1'b1, 1'b0);
    chk("seq_instret", instret, 32'd5);
    chk("seq_pc", pc, 32'h14);

    // Backpressure on both channels.
    run_instr(m_pc + 32'd4, 3, 2, 4, 1'b1, 1'b0);
    // Jump back to 0x8, then redirect from 0x8 to 0x100.
    run_instr(32'h8, 0, 1, 0, 1'b1, 1'b0);
    run_instr(32'h100, 0, 0, 0, 1'b1, 1'b0);
    chk("redirect_addr", imem_addr, 32'h100);

    // Randomized aligned stream.
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 0) nxt = m_pc + 32'd4;
      else                           nxt = $urandom & 32'hFFFF_FFFC;
      run_instr(nxt, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'b1, 1'b0);
    end

    // Misaligned target: trap, absorbing.
    run_instr(32'h102, 0, 0, 1, 1'b1, 1'b0);
    chk("mis_pc", pc, 32'h102);
    for (int k = 0; k < 8; k++) begin
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b1;
      inst_ready     = 1'b1;
      dnpc           = $urandom;
      @(negedge clk);
      chk1("trap_req_low", imem_req_valid, 1'b0);
      chk1("trap_inst_low", inst_valid, 1'b0);
      chk("trap_pc", pc, m_pc);
      chk("trap_instret", instret, m_instret);
      chk1("trap_mis", misalign_err, 1'b1);
    end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;

    // Reset clears the sticky flag.
    rst_n = 1'b0;
    #1;
    model_reset();
    chk1("rst2_mis", misalign_err, 1'b0);
    chk("rst2_pc", pc, RESET_PC);
    chk("rst2_instret", instret, 32'h0);
    chk("rst2_inst", inst, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while WAIT has an outstanding request; late response is dropped.
    @(negedge clk);
    chk1("w_req", imem_req_valid, 1'b1);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk1("w_in_wait", imem_req_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("w_rst_req", imem_req_valid, 1'b0);
    chk1("w_rst_iv", inst_valid, 1'b0);
    @(negedge clk);
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk1("late_rsp_iv", inst_valid, 1'b0);
    chk1("late_rsp_req", imem_req_valid, 1'b1);
    chk("late_rsp_addr", imem_addr, RESET_PC);
    chk("late_rsp_inst", inst, 32'h0);
    @(negedge clk);
    chk1("late_rsp_iv2", inst_valid, 1'b0);
    chk("late_rsp_inst2", inst, 32'h0);
    imem_rsp_valid = 1'b0;

    // Counter wrap, then a normal increment after it.
    run_instr(m_pc + 32'd4, 0, 0, 0, 1'b1, 1'b1);
    chk("wrap_zero", instret, 32'h0);
    run_instr(m_pc + 32'd4, 0, 0, 0, 1'b1, 1'b0);
    chk("wrap_one", instret, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
